// File: rtl/rr_burst_reg_arbiter.sv
// Round-robin arbiter with a per-winner burst allowance, feeding one registered output word.
// Accepted words appear one cycle later; req_ready is held low while the output is full and stalled.
module rr_burst_reg_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic                       out_ready,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(NUM_REQ)-1:0] out_src
);

   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DATA_W-1:0] r_data;
   logic [SRC_W-1:0] r_src;
   logic [SRC_W-1:0] r_last;
   logic [CNT_W-1:0] r_burst;

   logic             w_any;
   logic             w_load;
   logic             w_sticky;
   logic             w_found;
   logic [SRC_W-1:0] w_winner;
   logic [SRC_W-1:0] w_idx;

   assign w_any    = |req_valid;
   assign w_load   = w_any && (!out_valid || out_ready);
   assign w_sticky = req_valid[r_last] && (r_burst < CNT_W'(MAX_BURST));

   // Scan starts just after last_grant and ends on last_grant itself, so a
   // sole requester with an exhausted burst is still picked.
   always_comb begin
      w_winner = r_last;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = SRC_W'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_winner = w_idx;
            w_found  = 1'b1;
         end
      end
      if (w_sticky) begin
         w_winner = r_last;
      end
   end

   assign req_ready = w_load ? (NUM_REQ'(1) << w_winner) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !w_load) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (r_state == ST_FULL);
      out_data  = r_data;
      out_src   = r_src;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_src   <= '0;
         r_last  <= SRC_W'(NUM_REQ - 1);
         r_burst <= CNT_W'(MAX_BURST);
      end else if (w_load) begin
         r_data <= req_data[int'(w_winner)*DATA_W +: DATA_W];
         r_src  <= w_winner;
         r_last <= w_winner;
         // A repeat win with the allowance used up comes from the scan
         // wrapping, which starts a fresh burst.
         if ((w_winner == r_last) && (r_burst < CNT_W'(MAX_BURST))) begin
            r_burst <= r_burst + CNT_W'(1);
         end else begin
            r_burst <= CNT_W'(1);
         end
      end
   end

endmodule
